// File: rtl/ram_req_ctrl.sv
// Request controller for a single-port RAM with a combinational read port.
// Serialises reads and writes with a strict strobe sequence and can fill the whole memory.
module ram_req_ctrl #(
  parameter int addr_size   = 10,
  parameter int word_size   = 8,
  parameter int memory_size = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [addr_size-1:0] req_addr,
  input  logic [word_size-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [word_size-1:0] rsp_rdata,
  input  logic                 init_start,
  input  logic [word_size-1:0] init_value,
  output logic                 init_busy,
  output logic                 init_done,
  output logic [addr_size-1:0] ram_addr,
  output logic [word_size-1:0] ram_data_in,
  output logic                 ram_wr,
  output logic                 ram_cs,
  input  logic [word_size-1:0] ram_data_out
);

  typedef enum logic [3:0] {
    IDLE,
    W_SETUP,
    W_PULSE,
    W_HOLD,
    RD,
    RESP,
    I_SETUP,
    I_PULSE,
    I_HOLD
  } state_t;

  localparam logic [addr_size-1:0] last_addr = addr_size'(memory_size - 1);

  state_t               state;
  logic [addr_size-1:0] fill_count;

  // Every output is registered; each transition loads the values the next state drives.
  // ram_addr/ram_data_in double as the latched request (or fill) address and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fill_count  <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      init_busy   <= 1'b0;
      init_done   <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
      ram_wr      <= 1'b0;
      ram_cs      <= 1'b0;
    end else begin
      init_done <= 1'b0;
      case (state)
        IDLE: begin
          if (init_start) begin
            state       <= I_SETUP;
            fill_count  <= '0;
            ram_addr    <= '0;
            ram_data_in <= init_value;
            ram_cs      <= 1'b1;
            ram_wr      <= 1'b0;
            init_busy   <= 1'b1;
            req_ready   <= 1'b0;
          end else if (req_valid && req_ready) begin
            ram_addr  <= req_addr;
            ram_cs    <= 1'b1;
            ram_wr    <= 1'b0;
            req_ready <= 1'b0;
            if (req_wr) begin
              state       <= W_SETUP;
              ram_data_in <= req_wdata;
            end else begin
              state <= RD;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end

        W_SETUP: begin
          state  <= W_PULSE;
          ram_wr <= 1'b1;
        end

        W_PULSE: begin
          state  <= W_HOLD;
          ram_wr <= 1'b0;
        end

        W_HOLD: begin
          state     <= IDLE;
          ram_cs    <= 1'b0;
          req_ready <= 1'b1;
        end

        RD: begin
          state     <= RESP;
          rsp_rdata <= ram_data_out;
          rsp_valid <= 1'b1;
          ram_cs    <= 1'b0;
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end

        I_SETUP: begin
          state  <= I_PULSE;
          ram_wr <= 1'b1;
        end

        I_PULSE: begin
          state  <= I_HOLD;
          ram_wr <= 1'b0;
        end

        // The last word ends the fill; the counter never wraps past memory_size-1.
        I_HOLD: begin
          if (fill_count == last_addr) begin
            state     <= IDLE;
            ram_cs    <= 1'b0;
            init_busy <= 1'b0;
            init_done <= 1'b1;
            req_ready <= 1'b1;
          end else begin
            state      <= I_SETUP;
            fill_count <= fill_count + 1'b1;
            ram_addr   <= fill_count + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          ram_wr    <= 1'b0;
          ram_cs    <= 1'b0;
          rsp_valid <= 1'b0;
          init_busy <= 1'b0;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Directed bench for ram_req_ctrl with a behavioural RAM (combinational read, strobed write).
module tb_ram_req_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [9:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       init_start;
  logic [7:0] init_value;
  logic       init_busy;
  logic       init_done;
  logic [9:0] ram_addr;
  logic [7:0] ram_data_in;
  logic       ram_wr;
  logic       ram_cs;
  logic [7:0] ram_data_out;

  logic [7:0] mem [0:1023];

  int checks;
  int passed;

  ram_req_ctrl #(.addr_size(10), .word_size(8), .memory_size(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .init_start  (init_start),
    .init_value  (init_value),
    .init_busy   (init_busy),
    .init_done   (init_done),
    .ram_addr    (ram_addr),
    .ram_data_in (ram_data_in),
    .ram_wr      (ram_wr),
    .ram_cs      (ram_cs),
    .ram_data_out(ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_data_out = mem[ram_addr];

  always @(posedge clk) begin
    if (ram_cs && ram_wr) mem[ram_addr] <= ram_data_in;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [9:0] addr, output logic [7:0] data, output logic ok);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = addr;
    step();
    req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (rsp_valid) ok = 1'b1;
      else step();
    end
    data = ok ? rsp_rdata : 8'hxx;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; init_start = 1'b0; init_value = '0;
    step();
    step();
    checks++; if (req_ready !== 1'b0) $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready); else passed++;
    checks++; if (ram_wr !== 1'b0) $display("[TB] FAIL reset_ram_wr: got %b expected 0", ram_wr); else passed++;
    checks++; if (ram_cs !== 1'b0) $display("[TB] FAIL reset_ram_cs: got %b expected 0", ram_cs); else passed++;
    checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else passed++;
    checks++; if (init_busy !== 1'b0 || init_done !== 1'b0) $display("[TB] FAIL reset_init: got busy=%b done=%b expected 0/0", init_busy, init_done); else passed++;
    checks++; if (ram_addr !== 10'h000 || ram_data_in !== 8'h00 || rsp_rdata !== 8'h00) $display("[TB] FAIL reset_data: got addr=%h din=%h rdata=%h expected zeros", ram_addr, ram_data_in, rsp_rdata); else passed++;
    rst = 1'b0;
    step();
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL reset_ready_after: got %b expected 1", req_ready); else passed++;
  endtask

  task automatic test_write();
    logic exp_wr  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic exp_cs  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic exp_rdy [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'h3A5; req_wdata = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      step();
      req_valid = 1'b0; req_addr = 10'h000; req_wdata = 8'h00;
      checks++; if (ram_wr !== exp_wr[i]) $display("[TB] FAIL write_ram_wr[%0d]: got %b expected %b", i, ram_wr, exp_wr[i]); else passed++;
      checks++; if (ram_cs !== exp_cs[i]) $display("[TB] FAIL write_ram_cs[%0d]: got %b expected %b", i, ram_cs, exp_cs[i]); else passed++;
      checks++; if (req_ready !== exp_rdy[i]) $display("[TB] FAIL write_req_ready[%0d]: got %b expected %b", i, req_ready, exp_rdy[i]); else passed++;
      if (i < 3) begin
        checks++; if (ram_addr !== 10'h3A5 || ram_data_in !== 8'hC3) $display("[TB] FAIL write_hold[%0d]: got addr=%h din=%h expected 3a5/c3", i, ram_addr, ram_data_in); else passed++;
      end
    end
  endtask

  task automatic test_read();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 10'h3A5;
    step();
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || ram_cs !== 1'b1 || ram_addr !== 10'h3A5) $display("[TB] FAIL read_rd_state: got valid=%b cs=%b addr=%h expected 0/1/3a5", rsp_valid, ram_cs, ram_addr); else passed++;
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hC3) $display("[TB] FAIL read_latency: got valid=%b rdata=%h expected 1/c3", rsp_valid, rsp_rdata); else passed++;
    checks++; if (ram_cs !== 1'b0) $display("[TB] FAIL read_resp_cs: got %b expected 0", ram_cs); else passed++;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hC3) $display("[TB] FAIL read_stall[%0d]: got valid=%b rdata=%h expected 1/c3", i, rsp_valid, rsp_rdata); else passed++;
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("[TB] FAIL read_release: got valid=%b ready=%b expected 0/1", rsp_valid, req_ready); else passed++;
    checks++; if (rsp_rdata !== 8'hC3) $display("[TB] FAIL read_retain: got %h expected c3", rsp_rdata); else passed++;
  endtask

  task automatic test_init();
    int busy_cycles;
    int done_pulses;
    logic [7:0] rd;
    logic ok;
    logic [9:0] addrs [4] = '{10'h000, 10'h1FF, 10'h3FF, 10'h010};
    init_value = 8'h5A; init_start = 1'b1;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'h010; req_wdata = 8'hFF;
    step();
    init_start = 1'b0; req_valid = 1'b0;
    checks++; if (init_busy !== 1'b1 || req_ready !== 1'b0) $display("[TB] FAIL init_start: got busy=%b ready=%b expected 1/0", init_busy, req_ready); else passed++;
    checks++; if (ram_addr !== 10'h000 || ram_data_in !== 8'h5A || ram_cs !== 1'b1) $display("[TB] FAIL init_priority: got addr=%h din=%h cs=%b expected 000/5a/1", ram_addr, ram_data_in, ram_cs); else passed++;
    busy_cycles = 1;
    done_pulses = 0;
    for (int i = 0; i < 3100; i++) begin
      step();
      if (init_busy) busy_cycles++;
      if (init_done) done_pulses++;
    end
    checks++; if (busy_cycles != 3072) $display("[TB] FAIL init_busy_cycles: got %0d expected 3072", busy_cycles); else passed++;
    checks++; if (done_pulses != 1) $display("[TB] FAIL init_done_pulses: got %0d expected 1", done_pulses); else passed++;
    checks++; if (req_ready !== 1'b1 || init_busy !== 1'b0) $display("[TB] FAIL init_end: got ready=%b busy=%b expected 1/0", req_ready, init_busy); else passed++;
    for (int i = 0; i < 4; i++) begin
      do_read(addrs[i], rd, ok);
      checks++; if (!ok || rd !== 8'h5A) $display("[TB] FAIL init_readback[%h]: got ok=%b data=%h expected 1/5a", addrs[i], ok, rd); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int accepts;
    int pulses;
    int gap_bad;
    int adjacent;
    int last_accept;
    int k;
    logic accept;
    logic prev_wr;
    logic [7:0] rd;
    logic ok;
    accepts = 0; pulses = 0; gap_bad = 0; adjacent = 0; last_accept = -1; k = 0; prev_wr = 1'b0;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'h200; req_wdata = 8'h40;
    for (int i = 0; i < 16; i++) begin
      accept = req_valid && req_ready;
      step();
      if (accept) begin
        if (last_accept >= 0 && i - last_accept != 4) gap_bad++;
        last_accept = i;
        accepts++;
        k++;
        req_addr  = 10'h200 + 10'(k);
        req_wdata = 8'h40 + 8'(k);
      end
      if (ram_wr) begin
        pulses++;
        if (prev_wr) adjacent++;
      end
      prev_wr = ram_wr;
    end
    req_valid = 1'b0;
    checks++; if (accepts != 4) $display("[TB] FAIL b2b_accepts: got %0d expected 4", accepts); else passed++;
    checks++; if (gap_bad != 0) $display("[TB] FAIL b2b_spacing: got %0d bad gaps expected 0", gap_bad); else passed++;
    checks++; if (pulses != 4 || adjacent != 0) $display("[TB] FAIL b2b_pulses: got pulses=%0d adjacent=%0d expected 4/0", pulses, adjacent); else passed++;
    do_read(10'h203, rd, ok);
    checks++; if (!ok || rd !== 8'h43) $display("[TB] FAIL b2b_read_203: got ok=%b data=%h expected 1/43", ok, rd); else passed++;
    do_read(10'h200, rd, ok);
    checks++; if (!ok || rd !== 8'h40) $display("[TB] FAIL b2b_read_200: got ok=%b data=%h expected 1/40", ok, rd); else passed++;
  endtask

  task automatic test_reset_mid_op();
    int stray;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'h0AA; req_wdata = 8'h77;
    step();
    req_valid = 1'b0;
    step();
    checks++; if (ram_wr !== 1'b1) $display("[TB] FAIL midrst_pulse: got %b expected 1", ram_wr); else passed++;
    rst = 1'b1;
    step();
    checks++; if (ram_wr !== 1'b0 || ram_cs !== 1'b0 || req_ready !== 1'b0 || ram_addr !== 10'h000) $display("[TB] FAIL midrst_write: got wr=%b cs=%b ready=%b addr=%h expected 0/0/0/000", ram_wr, ram_cs, req_ready, ram_addr); else passed++;
    rst = 1'b0;
    step();
    checks++; if (req_ready !== 1'b1 || ram_cs !== 1'b0) $display("[TB] FAIL midrst_idle: got ready=%b cs=%b expected 1/0", req_ready, ram_cs); else passed++;
    init_value = 8'h5A; init_start = 1'b1;
    step();
    init_start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (init_busy || init_done || ram_cs || ram_wr) stray++;
    end
    checks++; if (stray != 0) $display("[TB] FAIL midrst_fill: got %0d active cycles expected 0", stray); else passed++;
  endtask

  task automatic test_init_in_resp();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 10'h200;
    step();
    req_valid = 1'b0;
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h40) $display("[TB] FAIL resp_enter: got valid=%b rdata=%h expected 1/40", rsp_valid, rsp_rdata); else passed++;
    init_value = 8'h11; init_start = 1'b1;
    step();
    checks++; if (init_busy !== 1'b0 || rsp_valid !== 1'b1) $display("[TB] FAIL resp_init_ignored: got busy=%b valid=%b expected 0/1", init_busy, rsp_valid); else passed++;
    init_start = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || init_busy !== 1'b0) $display("[TB] FAIL resp_exit: got valid=%b busy=%b expected 0/0", rsp_valid, init_busy); else passed++;
    step();
    checks++; if (init_busy !== 1'b0 || ram_cs !== 1'b0 || req_ready !== 1'b1) $display("[TB] FAIL resp_after: got busy=%b cs=%b ready=%b expected 0/0/1", init_busy, ram_cs, req_ready); else passed++;
  endtask

  // Scenarios run in order; each leaves the controller idle for the next.
  initial begin
    checks = 0;
    passed = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_init();
    test_back_to_back();
    test_reset_mid_op();
    test_init_in_resp();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
